// File: rtl/adaptive_mul_ctrl.sv
// Iterative signed 32x32->64 radix-4 Booth multiplier with early termination.
// The narrower operand (more redundant sign bits) becomes the Booth multiplier,
// partial products accumulate in carry-save form, and one final add resolves.

// Leading-zero counter: returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] x,
  output logic [5:0]  cnt
);
  // Ascending scan so the highest set bit determines the final count
  always_comb begin
    cnt = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (x[i]) cnt = 6'(31 - i);
    end
  end
endmodule

// 3:2 carry-save adder; carry output is pre-shifted with bit 0 left zero.
module csa_3_2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
endmodule

module adaptive_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [4:0]         iter_count
);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_RESOLVE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a, op_b;
  logic [32:0] m_bits;      // {M, M[-1]} shifted right two bits per digit
  logic [63:0] d_sh;        // sign-extended multiplicand, shifted left 2i
  logic [63:0] sum_q, carry_q;
  logic [4:0]  cnt_q;

  // Redundant sign-bit count: leading zeros of adjacent-bit differences
  logic [5:0]  lb_a, lb_b, lb_m, n_bits;
  logic [31:0] m_sel, d_sel;
  logic [4:0]  k_sel;

  lzc32 u_lzc_a (.x({op_a[31:1] ^ op_a[30:0], 1'b1}), .cnt(lb_a));
  lzc32 u_lzc_b (.x({op_b[31:1] ^ op_b[30:0], 1'b1}), .cnt(lb_b));

  // Operand selection and digit count; ties pick b as the multiplier
  always_comb begin
    if (lb_a > lb_b) begin
      m_sel = op_a;
      d_sel = op_b;
      lb_m  = lb_a;
    end else begin
      m_sel = op_b;
      d_sel = op_a;
      lb_m  = lb_b;
    end
    n_bits = 6'd32 - lb_m;
    k_sel  = 5'((n_bits + 6'd1) >> 1);
  end

  // Booth digit recode and partial product; negation is ~pp plus an LSB carry-in
  logic [2:0]  dig;
  logic        neg, is_zero, is_two;
  logic [63:0] pp, pp_in, csa_s, csa_c;

  always_comb begin
    dig     = m_bits[2:0];
    is_zero = (dig == 3'b000) || (dig == 3'b111);
    is_two  = (dig == 3'b011) || (dig == 3'b100);
    neg     = dig[2] && !is_zero;
    pp      = is_zero ? '0 : (is_two ? (d_sh << 1) : d_sh);
    pp_in   = neg ? ~pp : pp;
  end

  csa_3_2 #(.W(64)) u_csa (.x(sum_q), .y(carry_q), .z(pp_in), .s(csa_s), .c(csa_c));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_PREP;
      S_PREP:    state_d = S_ITER;
      S_ITER:    if (cnt_q == iter_count - 5'd1) state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath: operand capture, carry-save accumulation, final resolve
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a       <= '0;
      op_b       <= '0;
      m_bits     <= '0;
      d_sh       <= '0;
      sum_q      <= '0;
      carry_q    <= '0;
      cnt_q      <= '0;
      iter_count <= '0;
      product    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_a <= a;
            op_b <= b;
          end
        end
        S_PREP: begin
          m_bits     <= {m_sel, 1'b0};
          d_sh       <= {{32{d_sel[31]}}, d_sel};
          sum_q      <= '0;
          carry_q    <= '0;
          cnt_q      <= '0;
          iter_count <= k_sel;
        end
        S_ITER: begin
          sum_q   <= csa_s;
          carry_q <= csa_c | {63'd0, neg};
          m_bits  <= {{2{m_bits[32]}}, m_bits[32:2]};
          d_sh    <= d_sh << 2;
          cnt_q   <= cnt_q + 5'd1;
        end
        S_RESOLVE: product <= sum_q + carry_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adaptive_mul_ctrl.sv
// Directed-vector and randomized bench for adaptive_mul_ctrl.
module tb_adaptive_mul_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [4:0]  iter_count;

  int total = 0;
  int bad   = 0;

  adaptive_mul_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_ready(in_ready),
    .a(op_a), .b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          k;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lb_ref(input logic [31:0] x);
    int c = 0;
    for (int i = 30; i >= 0; i--) begin
      if (x[i] != x[31]) break;
      c++;
    end
    return c;
  endfunction

  // Issue one op, wait for the result, capture it, then take it.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [63:0] p, output int k, output int lat);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    op_a = av; op_b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    p = product;
    k = int'(iter_count);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    logic [63:0] p;
    int k, lat, kr, g;
    logic [31:0] ra, rb;
    bit saw_valid;

    vecs[0]  = '{32'h00000003, 32'h00000005, 64'h000000000000000F, 2};
    vecs[1]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF80000001, 1};
    vecs[2]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 16};
    vecs[3]  = '{32'h12345678, 32'h00000000, 64'h0000000000000000, 1};
    vecs[4]  = '{32'hFFFFFFF9, 32'h00000006, 64'hFFFFFFFFFFFFFFD6, 2};
    vecs[5]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 16};
    vecs[6]  = '{32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 1};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1};
    vecs[8]  = '{32'h00010000, 32'hFFFF0000, 64'hFFFFFFFF00000000, 9};
    vecs[9]  = '{32'h00000064, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFED4, 2};
    vecs[10] = '{32'h40000000, 32'h40000000, 64'h1000000000000000, 16};

    resetn = 1'b0; start = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_iter_count", 64'(iter_count), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, p, k, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].p);
      check($sformatf("vec%0d_iter", i), 64'(k), 64'(vecs[i].k));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].k + 2));
      check($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 64'd0);
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      check($sformatf("vec%0d_hold", i), product, vecs[i].p);
    end

    // Reset in the middle of a 16-digit op discards it
    op_a = 32'h80000000; op_b = 32'h80000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_product", product, 64'd0);
    check("midrst_iter_count", 64'(iter_count), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", 64'(saw_valid), 64'd0);
    run_op(32'hFFFFFFF9, 32'h00000006, p, k, lat);
    check("postrst_product", p, 64'hFFFFFFFFFFFFFFD6);
    check("postrst_iter", 64'(k), 64'd2);
    check("postrst_latency", 64'(lat), 64'd4);

    // Consumer stall with an ignored start pulse
    op_a = 32'h12345678; op_b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (!out_valid && g < 40) begin
      @(posedge clk); #1; g++;
    end
    check("stall_latency", 64'(g), 64'd3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        op_a = 32'h00000005; op_b = 32'h00000005; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_product", c), product, 64'd0);
      check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d_iter", c), 64'(iter_count), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    saw_valid = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("stall_start_ignored", 64'(saw_valid), 64'd0);
    check("stall_product_hold", product, 64'd0);

    // Randomized against a behavioural reference
    for (int n = 0; n < 2000; n++) begin
      for (int s = 0; s < 2; s++) begin
        logic [31:0] v;
        case ($urandom_range(0, 7))
          0: v = 32'h80000000;
          1: v = 32'h7FFFFFFF;
          2: v = ($urandom_range(0, 1) != 0) ? 32'h00000001 : 32'hFFFFFFFF;
          3: v = 32'($signed($urandom) >>> $urandom_range(0, 31));
          4: v = $urandom >> $urandom_range(0, 31);
          default: v = $urandom;
        endcase
        if (s == 0) ra = v; else rb = v;
      end
      kr = (32 - ((lb_ref(ra) > lb_ref(rb)) ? lb_ref(ra) : lb_ref(rb)) + 1) / 2;
      run_op(ra, rb, p, k, lat);
      check($sformatf("rnd%0d_product %h*%h", n, ra, rb), p,
            64'($signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb})));
      check($sformatf("rnd%0d_iter", n), 64'(k), 64'(kr));
      check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(kr + 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
